// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a 4x4 matrix keypad by driving one column low at a time and sampling
// the active-low rows. Presses and releases are debounced over whole scan
// frames (four column dwells). An accepted key is reported as a 4-bit code
// (4*row + col) together with a one-cycle valid strobe.
//
// Ports:
//   clk        system clock
//   clr        synchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, exactly one bit low at any time
//   key_code   code of the last accepted key (held until the next acceptance)
//   key_valid  one-cycle pulse per accepted key (and per repeat, if enabled)
//   key_held   high while the accepted key remains pressed
//
// Parameters:
//   SCAN_DIV_BITS    prescaler width, column dwell = 2**SCAN_DIV_BITS cycles
//   DEBOUNCE_FRAMES  identical frames needed to accept a press or a release
//   REPEAT_FRAMES    auto-repeat period in frames (KEYPAD_REPEAT_EN only)
//
// Build option:
//   KEYPAD_REPEAT_EN  when defined, a held key re-strobes key_valid every
//                     REPEAT_FRAMES frames; when undefined there is exactly
//                     one key_valid per accepted press.
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
    parameter int SCAN_DIV_BITS   = 13,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // Parameter legality is checked at elaboration time.
    if (SCAN_DIV_BITS < 3) begin : g_bad_scan_div
        $error("keypad_matrix_scanner: SCAN_DIV_BITS must be >= 3");
    end
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
        $error("keypad_matrix_scanner: DEBOUNCE_FRAMES must be 1..15");
    end
    if (REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_repeat
        $error("keypad_matrix_scanner: REPEAT_FRAMES must be 2..255");
    end

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_FRAMES);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_TARGET = 8'(REPEAT_FRAMES);
`endif

    logic [3:0]               row_meta_q, row_meta_d;
    logic [3:0]               row_sync_q, row_sync_d;
    logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
    logic [1:0]               col_idx_q, col_idx_d;
    logic [3:0]               col_q, col_d;
    logic [15:0]              hits_q, hits_d;
    logic [1:0]               state_q, state_d;
    logic [3:0]               cand_q, cand_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [3:0]               rel_cnt_q, rel_cnt_d;
    logic [3:0]               key_code_q, key_code_d;
    logic                     key_valid_q, key_valid_d;
    logic                     key_held_q, key_held_d;
`ifdef KEYPAD_REPEAT_EN
    logic [7:0]               rep_cnt_q, rep_cnt_d;
`endif

    logic       tick;
    logic       frame_eval;
    logic [3:0] row_hit;
    logic [1:0] n_hit;       // saturating: 0 = NONE, 1 = SINGLE, 2 = MULTI
    logic [3:0] single_key;

    assign tick       = &presc_q;
    assign frame_eval = tick && (col_idx_q == 2'd3);
    assign row_hit    = ~row_sync_q;

    // -------------------------------------------------------------------------
    // Scan timing and frame capture
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        row_meta_d = row;
        row_sync_d = row_meta_q;
        presc_d    = presc_q + {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};
        col_idx_d  = col_idx_q;
        col_d      = col_q;
        hits_d     = hits_q;

        if (tick) begin
            // Record the four intersections of the column being driven; bit
            // index 4*row + col equals the key code of that intersection.
            for (int r = 0; r < 4; r++) begin
                hits_d[{2'(r), col_idx_q}] = row_hit[r];
            end
            col_idx_d = col_idx_q + 2'd1;
            col_d     = ~(4'b0001 << col_idx_d);
        end

        // Classify the completed frame (includes the column-3 sample taken
        // this very cycle, hence hits_d rather than hits_q).
        n_hit      = 2'd0;
        single_key = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hits_d[i]) begin
                if (n_hit == 2'd0) begin
                    single_key = 4'(i);
                end
                if (n_hit != 2'd2) begin
                    n_hit = n_hit + 2'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM, advanced once per frame on the column-3 tick
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif

        if (frame_eval) begin
            case (state_q)
                ST_IDLE: begin
                    if (n_hit == 2'd1) begin
                        if (DEB_TARGET == 4'd1) begin
                            key_code_d  = single_key;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rel_cnt_d   = 4'd0;
                            cnt_d       = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = 8'd0;
`endif
                            state_d     = ST_HELD;
                        end else begin
                            cand_d  = single_key;
                            cnt_d   = 4'd1;
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (n_hit == 2'd1 && single_key == cand_q) begin
                        if (cnt_q + 4'd1 == DEB_TARGET) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            rel_cnt_d   = 4'd0;
                            cnt_d       = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = 8'd0;
`endif
                            state_d     = ST_HELD;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (n_hit == 2'd1) begin
                        // A different single key restarts the run on it.
                        cand_d = single_key;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end
                end

                ST_HELD: begin
                    // Only a run of empty frames releases; any key activity,
                    // including a second key, keeps the current key held.
                    if (n_hit == 2'd0) begin
                        if (rel_cnt_q + 4'd1 == DEB_TARGET) begin
                            rel_cnt_d  = 4'd0;
                            key_held_d = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 4'd1;
                        end
                    end else begin
                        rel_cnt_d = 4'd0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (n_hit == 2'd1 && single_key == key_code_q) begin
                        if (rep_cnt_q + 8'd1 == REP_TARGET) begin
                            rep_cnt_d   = 8'd0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 8'd1;
                        end
                    end else begin
                        rep_cnt_d = 8'd0;
                    end
`endif
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers; clr overrides any tick or frame evaluation
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (clr) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            presc_q     <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            // NOTE: the per-frame hit map is cleared too; although each frame
            // rewrites it fully, clearing keeps the first frame well defined.
            hits_q      <= 16'd0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            rel_cnt_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= 8'd0;
`endif
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            presc_q     <= presc_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//
// Bench for keypad_matrix_scanner with an 8-clock column dwell (32-clock
// frame). A keypad model turns a 16-bit "pressed keys" mask into row levels
// from the driven columns. Stimulus changes only on frame boundaries, and a
// frame-level reference model applies the debounce rules to each mask to
// predict key_valid, key_code and key_held at the end of every frame.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

    localparam int SDB   = 3;
    localparam int DEB   = 4;
    localparam int REP   = 2;
    localparam int DWELL = 1 << SDB;
    localparam int FRAME = 4 * DWELL;

    localparam int P_IDLE = 0;
    localparam int P_DEB  = 1;
    localparam int P_HELD = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model state.
    int         m_phase;
    int         m_cand;
    int         m_cnt;
    int         m_rel;
    int         m_rep;
    logic [3:0] m_code;

    keypad_matrix_scanner #(
        .SCAN_DIV_BITS  (SDB),
        .DEBOUNCE_FRAMES(DEB),
        .REPEAT_FRAMES  (REP)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r + c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] key_mask(input int k);
        logic [15:0] m;
        m = 16'd0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_cand  = -1;
        m_cnt   = 0;
        m_rel   = 0;
        m_rep   = 0;
        m_code  = 4'd0;
    endtask

    // Apply one frame of pressed keys to the debounce rules.
    task automatic model_frame(input logic [15:0] mask, output bit exp_valid);
        int n;
        int k;
        n = $countones(mask);
        k = -1;
        if (n == 1) begin
            for (int i = 0; i < 16; i++) if (mask[i]) k = i;
        end
        exp_valid = 1'b0;
        if (m_phase == P_HELD) begin
            if (n == 0) begin
                m_rel++;
                if (m_rel == DEB) begin
                    m_phase = P_IDLE;
                    m_rel   = 0;
                end
            end else begin
                m_rel = 0;
            end
`ifdef KEYPAD_REPEAT_EN
            if (k == int'(m_code)) begin
                m_rep++;
                if (m_rep == REP) begin
                    exp_valid = 1'b1;
                    m_rep     = 0;
                end
            end else begin
                m_rep = 0;
            end
`endif
        end else if (k >= 0) begin
            if (m_phase == P_DEB && k == m_cand) m_cnt++;
            else begin
                m_cand = k;
                m_cnt  = 1;
            end
            if (m_cnt == DEB) begin
                m_code    = 4'(k);
                exp_valid = 1'b1;
                m_phase   = P_HELD;
                m_cnt     = 0;
                m_rel     = 0;
                m_rep     = 0;
            end else begin
                m_phase = P_DEB;
            end
        end else begin
            m_phase = P_IDLE;
            m_cnt   = 0;
        end
    endtask

    // Called at the negedge just before a frame starts; returns at the negedge
    // just before the next frame starts.
    task automatic run_frame(input logic [15:0] mask, input string name);
        bit         exp_v;
        int         pulses;
        bit         early;
        bit         col_bad;
        logic [3:0] code_seen;
        logic [3:0] exp_col;
        logic       exp_held;
        pressed = mask;
        model_frame(mask, exp_v);
        exp_held  = (m_phase == P_HELD);
        pulses    = 0;
        early     = 1'b0;
        col_bad   = 1'b0;
        code_seen = 4'd0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << (((i + 1) / DWELL) % 4));
            if (col !== exp_col) col_bad = 1'b1;
            if (key_valid === 1'b1) begin
                pulses++;
                code_seen = key_code;
                if (i != FRAME - 1) early = 1'b1;
            end else if (key_valid !== 1'b0) begin
                early = 1'b1;
            end
        end
        checks++;
        if (pulses != int'(exp_v) || early) begin
            failures++;
            $display("FAIL %s key_valid: pulses=%0d (mistimed=%0d) expected=%0d",
                     name, pulses, early, exp_v);
        end
        if (exp_v) begin
            checks++;
            if (code_seen !== m_code) begin
                failures++;
                $display("FAIL %s key_code: got=%0d expected=%0d", name, code_seen, m_code);
            end
        end
        checks++;
        if (key_held !== exp_held) begin
            failures++;
            $display("FAIL %s key_held: got=%b expected=%b", name, key_held, exp_held);
        end
        checks++;
        if (col_bad) begin
            failures++;
            $display("FAIL %s col rotation: last col=%b", name, col);
        end
        @(negedge clk);
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n, input string name);
        for (int f = 0; f < n; f++) run_frame(mask, name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (col !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL %s: col=%b code=%0d valid=%b held=%b expected col=1110 code=0 valid=0 held=0",
                     name, col, key_code, key_valid, key_held);
        end
    endtask

    task automatic test_reset();
        pressed = 16'd0;
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        run_frames(16'd0, 2, "reset_rotate");
    endtask

    task automatic test_clean_press();
        run_frames(key_mask(9), 6, "clean_press_k9");
        run_frames(16'd0, 5, "clean_release_k9");
    endtask

    task automatic test_bounce();
        run_frames(key_mask(6), 2, "bounce_k6_a");
        run_frame(16'd0, "bounce_gap");
        run_frames(key_mask(6), 4, "bounce_k6_b");
        run_frames(16'd0, 4, "bounce_release");
    endtask

    task automatic test_ghost();
        run_frames(key_mask(0) | key_mask(5), 10, "ghost_k0_k5");
        run_frames(key_mask(0), 4, "ghost_then_k0");
        run_frames(16'd0, 4, "ghost_release");
    endtask

    task automatic test_held_second_key();
        run_frames(key_mask(3), 4, "held_k3");
        run_frames(key_mask(3) | key_mask(15), 2, "held_k3_k15");
        run_frames(key_mask(15), 3, "held_k15_only");
        run_frames(16'd0, 4, "held_full_release");
        run_frames(key_mask(15), 4, "second_k15");
        run_frames(16'd0, 4, "second_release");
    endtask

    task automatic test_clr_debounce();
        bit bad;
        do_reset();
        run_frames(key_mask(3), 4, "pre_clr_k3");
        run_frames(16'd0, 4, "pre_clr_release");
        run_frames(key_mask(12), 2, "clr_k12_frames");
        // Third frame of key 12, cut short by clr.
        pressed = key_mask(12);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (key_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL clr_pre_valid: key_valid seen=1 expected=0");
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("clr_mid_debounce");
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        run_frames(key_mask(12), 4, "post_clr_k12");
    endtask

    task automatic test_repeat();
        run_frames(key_mask(12), 6, "repeat_k12");
        run_frames(16'd0, 4, "repeat_release");
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int          kind;
        int          k1;
        int          k2;
        for (int s = 0; s < 30; s++) begin
            kind = int'($urandom_range(0, 3));
            k1   = int'($urandom_range(0, 15));
            k2   = (k1 + int'($urandom_range(1, 15))) % 16;
            case (kind)
                0:       mask = 16'd0;
                3:       mask = key_mask(k1) | key_mask(k2);
                default: mask = key_mask(k1);
            endcase
            run_frames(mask, int'($urandom_range(1, 6)), "random");
        end
        run_frames(16'd0, 4, "random_release");
    endtask

    initial begin
        clr     = 1'b1;
        pressed = 16'd0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_held_second_key();
        test_clr_debounce();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Scans a 4x4 matrix keypad, the coin/product selection input of the vending machine. It drives one column low at a time and samples the active-low rows. Each detected key is debounced over whole scan frames and reported as a 4-bit code with a one-cycle valid strobe. It is the input-side counterpart of the multiplexed seven-segment display driver: time-multiplexed reading of a matrix instead of time-multiplexed writing.

Parameters:
SCAN_DIV_BITS, 13, prescaler width; column dwell = 2^SCAN_DIV_BITS clk cycles; legal minimum 3
DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a press and to accept a release; legal range 1..15
REPEAT_FRAMES, 32, auto-repeat period in frames; used only with KEYPAD_REPEAT_EN; legal range 2..255

Ports:
clk  input  1  system clock
clr  input  1  synchronous active-high reset
row  input  4  keypad rows, active-low, externally pulled up, asynchronous
col  output 4  keypad column drive, active-low, exactly one bit low at all times
key_code  output 4  code of the last accepted key = 4*row_index + col_index
key_valid  output 1  one-cycle pulse when a key is accepted
key_held  output 1  high while an accepted key is still pressed

Behaviour:
- One clock (clk). Reset is synchronous and active-high (clr).
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0. Prescaler, column index, counters and FSM all clear; state=IDLE.
- row passes through a 2-flop synchronizer before use.
- Prescaler counts clk cycles. A tick occurs when the prescaler is all-ones.
- On each tick: sample the synchronized row for the current column, then advance the column index 0->1->2->3->0. col is a registered one-hot-low of the column index (index c drives col[c]=0).
- A frame is the 4 ticks for columns 0..3. The frame result is evaluated on the column-3 tick:
  - NONE: no row low in any column.
  - SINGLE(k): exactly one row/column intersection low.
  - MULTI: two or more intersections low. Ghosting is never resolved.
- Debounce FSM, updated once per frame, in the cycle after the column-3 tick:
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to DEBOUNCE. If DEBOUNCE_FRAMES=1, accept immediately instead.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES: key_code<=cand, key_valid=1 for exactly one cycle, key_held<=1, rel_cnt=0, go to HELD.
    - SINGLE(other): cand=other, cnt=1, stay in DEBOUNCE.
    - NONE or MULTI: cnt=0, go to IDLE.
  - HELD:
    - NONE: rel_cnt++. When rel_cnt reaches DEBOUNCE_FRAMES: key_held<=0, go to IDLE.
    - SINGLE(any) or MULTI: rel_cnt=0, stay in HELD.
    - No rollover: a second key pressed while held never produces key_valid.
- key_code holds its value until the next acceptance; it is not cleared on release.
- Latency: key_valid rises 1 clk after the column-3 tick of the DEBOUNCE_FRAMES-th matching frame.
- clr asserted mid-operation takes priority over any tick or frame evaluation. It drops any pending candidate and produces no key_valid.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: auto-repeat. In HELD, a repeat counter counts frames whose result is SINGLE(key_code). Any other frame result clears it. When the counter reaches REPEAT_FRAMES, key_valid pulses one cycle (key_code unchanged) and the counter clears.
- Undefined: no repeat logic; one key_valid per accepted press. REPEAT_FRAMES is ignored.

Test Plan:
Bench parameters: SCAN_DIV_BITS=3 (8-clk dwell, 32-clk frame), DEBOUNCE_FRAMES=4.
- Reset: pulse clr for 2 cycles with row=4'hF -> col=1110, key_code=0, key_valid=0, key_held=0; col then rotates 1101, 1011, 0111 every 8 clks.
- Clean press: bench model holds row[2]=0 whenever col[1]=0 -> exactly one key_valid pulse with key_code=9 after the 4th frame; key_held=1 stays while held. Release -> key_held=0 after 4 NONE frames.
- Bounce: key 6 (row1/col2) present 2 frames, absent 1, present 4 -> exactly one key_valid, code 6, at the end of the 4-frame run.
- Ghost: keys 0 and 5 pressed together from IDLE for 10 frames -> no key_valid, key_held stays 0. Then releasing key 5 -> key_valid with code 0 after 4 frames.
- Held-then-second-key: hold key 3, accept, then add key 15 and release key 3 -> no new key_valid while held. After a full release (4 NONE frames), pressing key 15 -> key_valid, code 15.
- clr during DEBOUNCE (frame 3 of key 12) -> no key_valid; outputs at reset values. With KEYPAD_REPEAT_EN and REPEAT_FRAMES=2, holding key 12 -> a key_valid pulse every 2 frames after acceptance.
